// File: rtl/gmii_tx_sched_pkg.sv
// Shared types and constants for the two-queue GMII transmit scheduler.
package gmii_tx_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        DRAIN,
        IFG
    } state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    localparam int unsigned DEF_PRE_BYTES = 7;
    localparam int unsigned DEF_IFG_BYTES = 12;
    localparam int unsigned DEF_CNT_W     = 32;

endpackage

// File: rtl/gmii_tx_prio_arb.sv
// Combinational TSN-gate eligibility and strict-priority pick between two ports.
module gmii_tx_prio_arb (
    input  logic [1:0] valid,
    input  logic [1:0] gate,
    output logic       grant_idx,
    output logic       hit
);

    logic [1:0] elig;

    always_comb begin
        elig      = valid & gate;
        hit       = |elig;
        // port 0 always wins when eligible
        grant_idx = ~elig[0] & elig[1];
    end

endmodule

// File: rtl/gmii_tx_sched.sv
// Shares one GMII TX interface between a time-critical port 0 and a best-effort port 1,
// adding preamble/SFD, inter-frame gap and underrun handling.
module gmii_tx_sched
    import gmii_tx_sched_pkg::*;
#(
    parameter int unsigned PRE_BYTES = DEF_PRE_BYTES,
    parameter int unsigned IFG_BYTES = DEF_IFG_BYTES,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic             gmii_tx_clk,
    input  logic             rst,
    input  logic [7:0]       s_data_0,
    input  logic             s_valid_0,
    input  logic             s_last_0,
    output logic             s_ready_0,
    input  logic [7:0]       s_data_1,
    input  logic             s_valid_1,
    input  logic             s_last_1,
    output logic             s_ready_1,
    input  logic [1:0]       tx_gate,
    output logic [7:0]       gmii_txd,
    output logic             gmii_tx_en,
    output logic             gmii_tx_er,
    output logic [CNT_W-1:0] tx_frames_0,
    output logic [CNT_W-1:0] tx_frames_1,
    output logic [15:0]      underrun_cnt
);

    localparam logic [15:0] PRE_LAST = 16'(PRE_BYTES - 1);
    localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 2);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic [15:0] ph_cnt_q, ph_cnt_d;
    logic [7:0]  txd_d;
    logic        en_d, er_d;
    logic        frame_done, underrun;
    logic        arb_idx, arb_hit;
    logic [7:0]  g_data;
    logic        g_valid, g_last, accepting;

    gmii_tx_prio_arb u_arb (
        .valid     ({s_valid_1, s_valid_0}),
        .gate      (tx_gate),
        .grant_idx (arb_idx),
        .hit       (arb_hit)
    );

    always_comb begin
        g_data    = grant_q ? s_data_1  : s_data_0;
        g_valid   = grant_q ? s_valid_1 : s_valid_0;
        g_last    = grant_q ? s_last_1  : s_last_0;
        accepting = (state_q == DATA) || (state_q == DRAIN);
        s_ready_0 = accepting && !grant_q;
        s_ready_1 = accepting &&  grant_q;
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ph_cnt_d   = ph_cnt_q;
        txd_d      = '0;
        en_d       = 1'b0;
        er_d       = 1'b0;
        frame_done = 1'b0;
        underrun   = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_hit) begin
                    grant_d  = arb_idx;
                    ph_cnt_d = '0;
                    state_d  = PRE;
                end
            end
            PRE: begin
                txd_d = PREAMBLE_BYTE;
                en_d  = 1'b1;
                if (ph_cnt_q == PRE_LAST) begin
                    ph_cnt_d = '0;
                    state_d  = SFD;
                end else begin
                    ph_cnt_d = ph_cnt_q + 16'd1;
                end
            end
            SFD: begin
                txd_d   = SFD_BYTE;
                en_d    = 1'b1;
                state_d = DATA;
            end
            DATA: begin
                en_d = 1'b1;
                if (g_valid) begin
                    txd_d = g_data;
                    if (g_last) begin
                        frame_done = 1'b1;
                        ph_cnt_d   = '0;
                        state_d    = IFG;
                    end
                end else begin
                    // upstream starved mid-frame: poison the wire and swallow the rest
                    er_d     = 1'b1;
                    underrun = 1'b1;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                if (g_valid && g_last) begin
                    ph_cnt_d = '0;
                    state_d  = IFG;
                end
            end
            IFG: begin
                if (ph_cnt_q == IFG_LAST) begin
                    ph_cnt_d = '0;
                    state_d  = IDLE;
                end else begin
                    ph_cnt_d = ph_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge gmii_tx_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            ph_cnt_q     <= '0;
            gmii_txd     <= '0;
            gmii_tx_en   <= 1'b0;
            gmii_tx_er   <= 1'b0;
            tx_frames_0  <= '0;
            tx_frames_1  <= '0;
            underrun_cnt <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ph_cnt_q   <= ph_cnt_d;
            gmii_txd   <= txd_d;
            gmii_tx_en <= en_d;
            gmii_tx_er <= er_d;
            if (frame_done && !grant_q) tx_frames_0 <= tx_frames_0 + CNT_W'(1);
            if (frame_done &&  grant_q) tx_frames_1 <= tx_frames_1 + CNT_W'(1);
            if (underrun && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
        end
    end

endmodule
